// File: rtl/qlow_frame_tx.sv
// Four-wire active-low frame transmitter: sync preamble, then escaped payload nibbles.
// Optional trailing parity nibble when QLOW_TX_PARITY_EN is defined.
module qlow_frame_tx #(
   parameter int FRAME_NIB = 4,
   parameter int SYNC_CYC  = 2
) (
   input  logic                   C,
   input  logic                   CLR_N,
   input  logic [4*FRAME_NIB-1:0] DI,
   input  logic                   DV,
   output logic                   DR,
   output logic [3:0]             O,
   output logic                   BUSY,
   output logic                   FDONE
);

   localparam int SR_W  = 4 * FRAME_NIB;
   localparam int CNT_W = $clog2(FRAME_NIB + 1);
   localparam int SC_W  = $clog2(SYNC_CYC + 1);
   localparam logic [CNT_W-1:0] NIB_ALL  = CNT_W'(FRAME_NIB);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [SC_W-1:0]  SYNC_ALL = SC_W'(SYNC_CYC);
   localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
`ifdef QLOW_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_ESC2,
      S_PAR
   } state_t;

   function automatic logic is_esc(input logic [3:0] n);
      return (n[3:1] == 3'b111);
   endfunction

   function automatic logic [3:0] first_sym(input logic [3:0] n);
      return is_esc(n) ? 4'hE : n;
   endfunction

   function automatic logic [3:0] esc_sym(input logic [3:0] n);
      return {3'b000, n[0]};
   endfunction

   state_t             state_q;
   logic [SR_W-1:0]    sr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SC_W-1:0]    scnt_q;
   logic [3:0]         o_q;
   logic               busy_q;
   logic               fdone_q;

   logic [SR_W-1:0]    sr_d;
   logic [3:0]         nib_cur;
   logic [3:0]         nib_nxt;
   logic               last_nib;
   logic               adv;

`ifdef QLOW_TX_PARITY_EN
   logic [3:0]         par_q;
   logic               in_par_q;

   function automatic logic [3:0] xor_nibbles(input logic [SR_W-1:0] d);
      logic [3:0] acc;
      acc = 4'h0;
      for (int i = 0; i < FRAME_NIB; i++) begin
         acc = acc ^ d[4*i +: 4];
      end
      return acc;
   endfunction
`endif

   assign sr_d     = sr_q << 4;
   assign nib_cur  = sr_q[SR_W-1 -: 4];
   assign nib_nxt  = sr_d[SR_W-1 -: 4];
   assign last_nib = (cnt_q == CNT_ONE);

   // A payload nibble is complete after its single symbol or its escape tail.
`ifdef QLOW_TX_PARITY_EN
   assign adv = ((state_q == S_DATA) && !is_esc(nib_cur)) ||
                ((state_q == S_ESC2) && !in_par_q);
`else
   assign adv = ((state_q == S_DATA) && !is_esc(nib_cur)) ||
                (state_q == S_ESC2);
`endif

   assign DR    = (state_q == S_IDLE);
   assign O     = o_q;
   assign BUSY  = busy_q;
   assign FDONE = fdone_q;

   // o_q always holds the line value for the cycle following the edge, so
   // FDONE is decided one symbol ahead from the remaining-nibble count.
   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q  <= S_IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         scnt_q   <= '0;
         o_q      <= 4'hF;
         busy_q   <= 1'b0;
         fdone_q  <= 1'b0;
`ifdef QLOW_TX_PARITY_EN
         par_q    <= 4'h0;
         in_par_q <= 1'b0;
`endif
      end else if (adv) begin
         sr_q  <= sr_d;
         cnt_q <= cnt_q - CNT_ONE;
         if (!last_nib) begin
            state_q <= S_DATA;
            o_q     <= ~first_sym(nib_nxt);
            fdone_q <= !PAR_EN && !is_esc(nib_nxt) && (cnt_q == CNT_TWO);
         end else begin
`ifdef QLOW_TX_PARITY_EN
            state_q  <= S_PAR;
            in_par_q <= 1'b1;
            o_q      <= ~first_sym(par_q);
            fdone_q  <= !is_esc(par_q);
`else
            state_q <= S_IDLE;
            o_q     <= 4'hF;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
`endif
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               fdone_q <= 1'b0;
               if (DV) begin
                  state_q <= S_SYNC;
                  sr_q    <= DI;
                  cnt_q   <= NIB_ALL;
                  scnt_q  <= SC_ONE;
                  o_q     <= 4'h0;
                  busy_q  <= 1'b1;
`ifdef QLOW_TX_PARITY_EN
                  par_q   <= xor_nibbles(DI);
`endif
               end
            end
            S_SYNC: begin
               if (scnt_q == SYNC_ALL) begin
                  state_q <= S_DATA;
                  scnt_q  <= '0;
                  o_q     <= ~first_sym(nib_cur);
                  fdone_q <= !PAR_EN && !is_esc(nib_cur) && (FRAME_NIB == 1);
               end else begin
                  scnt_q <= scnt_q + SC_ONE;
                  o_q    <= 4'h0;
               end
            end
            S_DATA: begin
               state_q <= S_ESC2;
               o_q     <= ~esc_sym(nib_cur);
               fdone_q <= !PAR_EN && last_nib;
            end
`ifdef QLOW_TX_PARITY_EN
            S_PAR: begin
               if (is_esc(par_q)) begin
                  state_q <= S_ESC2;
                  o_q     <= ~esc_sym(par_q);
                  fdone_q <= 1'b1;
               end else begin
                  state_q  <= S_IDLE;
                  in_par_q <= 1'b0;
                  o_q      <= 4'hF;
                  busy_q   <= 1'b0;
                  fdone_q  <= 1'b0;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
`ifdef QLOW_TX_PARITY_EN
               in_par_q <= 1'b0;
`endif
               o_q     <= 4'hF;
               busy_q  <= 1'b0;
               fdone_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
